// File: rtl/key_event_encoder.sv
// key_event_encoder: turns debounced key levels into press/auto-repeat events
// for the lowest pressed key, handed over through a one-deep output register.
module key_event_encoder #(
  parameter int NKEYS        = 16,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NKEYS-1:0] db_keys,
  output logic [3:0]       key_code,
  output logic             key_repeat,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             overflow,
  input  logic             overflow_clr
);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] DLY_LD  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LD = TW'(REPEAT_RATE - 1);
  localparam logic [1:0] IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2, WAIT_RELEASE = 2'd3;

  logic [NKEYS-1:0] r_sync1, r_skeys;
  logic [1:0]       r_state, w_state_n;
  logic [TW-1:0]    r_timer, w_timer_n;
  logic [3:0]       r_cur_key, w_cur_n, w_low;
  logic             w_gen, w_gen_rep, w_held, w_any;
  logic             r_ev_valid, r_ev_rep;
  logic [3:0]       r_ev_code;
  logic [3:0]       r_key_code;
  logic             r_key_repeat, r_key_valid, r_overflow;

  assign w_any  = |r_skeys;
  assign w_held = r_skeys[r_cur_key];

  always_comb begin
    w_low = 4'd0;
    for (int i = NKEYS - 1; i >= 0; i--)
      if (r_skeys[i]) w_low = 4'(i);
  end

  always_comb begin
    w_state_n = r_state;
    w_timer_n = r_timer;
    w_cur_n   = r_cur_key;
    w_gen     = 1'b0;
    w_gen_rep = 1'b0;
    case (r_state)
      IDLE: if (w_any) begin
        w_gen     = 1'b1;
        w_cur_n   = w_low;
        w_timer_n = DLY_LD;
        w_state_n = DELAY;
      end
      DELAY, REPEAT:
        if (!w_held) w_state_n = WAIT_RELEASE;
        else if (r_timer == '0) begin
          w_gen     = 1'b1;
          w_gen_rep = 1'b1;
          w_timer_n = RATE_LD;
          w_state_n = REPEAT;
        end else w_timer_n = r_timer - 1'b1;
      default: w_state_n = w_any ? WAIT_RELEASE : IDLE;
    endcase
  end

  // Event is staged one cycle before the output register so press latency is three edges past capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1      <= '0;
      r_skeys      <= '0;
      r_state      <= IDLE;
      r_timer      <= '0;
      r_cur_key    <= '0;
      r_ev_valid   <= 1'b0;
      r_ev_rep     <= 1'b0;
      r_ev_code    <= '0;
      r_key_code   <= '0;
      r_key_repeat <= 1'b0;
      r_key_valid  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_sync1    <= db_keys;
      r_skeys    <= r_sync1;
      r_state    <= w_state_n;
      r_timer    <= w_timer_n;
      r_cur_key  <= w_cur_n;
      r_ev_valid <= w_gen;
      r_ev_rep   <= w_gen_rep;
      r_ev_code  <= (r_state == IDLE) ? w_low : r_cur_key;
      if (r_ev_valid && (!r_key_valid || key_ready)) begin
        r_key_code   <= r_ev_code;
        r_key_repeat <= r_ev_rep;
        r_key_valid  <= 1'b1;
      end else if (r_key_valid && key_ready) r_key_valid <= 1'b0;
      if (r_ev_valid && r_key_valid && !key_ready) r_overflow <= 1'b1;
      else if (overflow_clr) r_overflow <= 1'b0;
    end
  end

  assign key_code   = r_key_code;
  assign key_repeat = r_key_repeat;
  assign key_valid  = r_key_valid;
  assign overflow   = r_overflow;
endmodule

// File: tb/tb_key_event_encoder.sv
// tb_key_event_encoder: directed scenarios with an event scoreboard checked
// by an independent monitor on every accepted output.
module tb_key_event_encoder;
  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] db = '0;
  logic [3:0]  key_code;
  logic        key_repeat, key_valid, overflow;
  logic        ready = 1'b1, clr = 1'b0;
  int          n_checks = 0, n_pass = 0, cyc = 0, last_cyc = 0, lat;

  typedef struct { logic [3:0] code; logic rep; int gap; } ev_t;
  ev_t q[$];

  key_event_encoder #(.NKEYS(16), .REPEAT_DELAY(8), .REPEAT_RATE(4)) dut (
    .clock(clk), .reset(rst), .db_keys(db), .key_code(key_code),
    .key_repeat(key_repeat), .key_valid(key_valid), .key_ready(ready),
    .overflow(overflow), .overflow_clr(clr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] code, input logic rep, input int gap);
    ev_t e;
    e.code = code;
    e.rep  = rep;
    e.gap  = gap;
    q.push_back(e);
  endtask

  task automatic wait_valid();
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (key_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  // Monitor: every handshake must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && key_valid && ready) begin
      if (q.size() == 0) chk("unexpected_event", {27'd0, key_repeat, key_code}, -1);
      else begin
        ev_t e;
        e = q.pop_front();
        chk("ev_code", int'(key_code), int'(e.code));
        chk("ev_repeat", int'(key_repeat), int'(e.rep));
        if (e.gap != 0) chk("ev_gap", cyc - last_cyc, e.gap);
        last_cyc = cyc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    step(2);
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_code", int'(key_code), 0);
    rst = 1'b0;
    step(2);
    push(4'd5, 1'b0, 0);
    db = 16'h0020;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (i == 3) db = '0;
      if (key_valid) begin
        lat = i;
        break;
      end
    end
    chk("press_latency", lat, 4);
    step(1);
    chk("single_pulse_valid", int'(key_valid), 0);
    step(20);
    chk("s1_drained", q.size(), 0);
    push(4'd0, 1'b0, 0);
    push(4'd0, 1'b1, 8);
    push(4'd0, 1'b1, 4);
    push(4'd0, 1'b1, 4);
    db = 16'h0001;
    step(20);
    db = '0;
    step(20);
    chk("s2_drained", q.size(), 0);
    push(4'd3, 1'b0, 0);
    db = 16'h0408;
    step(4);
    db = 16'h0400;
    step(10);
    db = '0;
    step(5);
    push(4'd10, 1'b0, 0);
    db = 16'h0400;
    step(4);
    db = '0;
    step(12);
    chk("s3_drained", q.size(), 0);
    ready = 1'b0;
    push(4'd2, 1'b0, 0);
    db = 16'h0004;
    step(14);
    db = '0;
    step(8);
    chk("stall_overflow", int'(overflow), 1);
    chk("stall_valid", int'(key_valid), 1);
    chk("stall_code", int'(key_code), 2);
    chk("stall_repeat", int'(key_repeat), 0);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("overflow_cleared", int'(overflow), 0);
    ready = 1'b1;
    step(1);
    chk("accept_clears_valid", int'(key_valid), 0);
    step(3);
    chk("s4_drained", q.size(), 0);
    ready = 1'b0;
    push(4'd4, 1'b0, 0);
    push(4'd4, 1'b1, 0);
    db = 16'h0010;
    wait_valid();
    chk("s5_latency", lat, 4);
    step(7);
    ready = 1'b1;
    step(1);
    chk("swap_valid", int'(key_valid), 1);
    chk("swap_repeat", int'(key_repeat), 1);
    chk("swap_code", int'(key_code), 4);
    chk("swap_overflow", int'(overflow), 0);
    db = '0;
    step(12);
    chk("s5_drained", q.size(), 0);
    push(4'd7, 1'b0, 0);
    push(4'd7, 1'b1, 8);
    db = 16'h0080;
    step(14);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", int'(key_valid), 0);
    chk("async_rst_code", int'(key_code), 0);
    chk("async_rst_repeat", int'(key_repeat), 0);
    chk("async_rst_overflow", int'(overflow), 0);
    step(1);
    push(4'd7, 1'b0, 0);
    rst = 1'b0;
    wait_valid();
    chk("post_rst_latency", lat, 4);
    db = '0;
    step(12);
    chk("s6_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
